// File: rtl/param_up_down_counter.sv
// Parameterised up/down counter with wrap, saturate, ping-pong and one-shot
// bound handling, sticky overflow/underflow flags and a terminal-count pulse.
module param_up_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             up_down,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] min_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             tc,
  output logic             done,
  output logic             ovf,
  output logic             udf,
  output logic             err
);

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_PING    = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_t;

  mode_t            mode_sel;
  logic             eff_up;
  logic [WIDTH:0]   sum_up;
  logic [WIDTH:0]   lim_dn;
  logic             up_evt;
  logic             dn_evt;
  logic [WIDTH-1:0] load_val;

  logic [WIDTH-1:0] count_n;
  logic             dir_n;
  logic             done_n;
  logic             tc_n;
  logic             set_ovf;
  logic             set_udf;

  assign mode_sel = mode_t'(mode);
  assign err      = (min_val > max_val);

  // Bound tests are done one bit wider so count+step and min+step never wrap.
  always_comb begin
    eff_up = (mode_sel == MODE_PING) ? dir : up_down;
    sum_up = {1'b0, count} + {1'b0, step};
    lim_dn = {1'b0, min_val} + {1'b0, step};
    up_evt = eff_up && (sum_up > {1'b0, max_val});
    dn_evt = !eff_up && ({1'b0, count} < lim_dn);
  end

  // Clamping is meaningless with inverted bounds, so load raw data then.
  always_comb begin
    load_val = data_in;
    if (!err) begin
      if (data_in < min_val)
        load_val = min_val;
      else if (data_in > max_val)
        load_val = max_val;
    end
  end

  always_comb begin
    count_n = count;
    dir_n   = dir;
    done_n  = done;
    tc_n    = 1'b0;
    set_ovf = 1'b0;
    set_udf = 1'b0;

    if (load) begin
      count_n = load_val;
      dir_n   = up_down;
      done_n  = 1'b0;
    end else if (err || done) begin
      count_n = count;
    end else if (en) begin
      if (mode_sel != MODE_PING)
        dir_n = up_down;
      if (up_evt) begin
        tc_n    = 1'b1;
        set_ovf = 1'b1;
        unique case (mode_sel)
          MODE_WRAP:    count_n = min_val;
          MODE_SAT:     count_n = max_val;
          MODE_PING: begin
            count_n = max_val;
            dir_n   = 1'b0;
          end
          MODE_ONESHOT: begin
            count_n = max_val;
            done_n  = 1'b1;
          end
          default:      count_n = count;
        endcase
      end else if (dn_evt) begin
        tc_n    = 1'b1;
        set_udf = 1'b1;
        unique case (mode_sel)
          MODE_WRAP:    count_n = max_val;
          MODE_SAT:     count_n = min_val;
          MODE_PING: begin
            count_n = min_val;
            dir_n   = 1'b1;
          end
          MODE_ONESHOT: begin
            count_n = min_val;
            done_n  = 1'b1;
          end
          default:      count_n = count;
        endcase
      end else if (eff_up) begin
        count_n = sum_up[WIDTH-1:0];
      end else begin
        count_n = count - step;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      dir   <= 1'b1;
      tc    <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      count <= count_n;
      dir   <= dir_n;
      tc    <= tc_n;
      done  <= done_n;
      // A same-cycle event beats clr_flags.
      ovf   <= (ovf & ~clr_flags) | set_ovf;
      udf   <= (udf & ~clr_flags) | set_udf;
    end
  end

endmodule

// File: tb/tb_param_up_down_counter.sv
// Directed bench for param_up_down_counter (WIDTH = 8) with hand-computed
// expected values checked by immediate assertions.
module tb_param_up_down_counter;
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             en;
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             up_down;
  logic [1:0]       mode;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] min_val;
  logic [WIDTH-1:0] max_val;
  logic             clr_flags;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             tc;
  logic             done;
  logic             ovf;
  logic             udf;
  logic             err;

  int n_checks = 0;
  int n_fail   = 0;

  param_up_down_counter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .data_in(data_in),
    .up_down(up_down), .mode(mode), .step(step), .min_val(min_val),
    .max_val(max_val), .clr_flags(clr_flags), .count(count), .dir(dir),
    .tc(tc), .done(done), .ovf(ovf), .udf(udf), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] wrap_exp [6];
    logic [7:0] pp_cnt [5];
    logic       pp_dir [5];

    rst = 1'b1; en = 1'b0; load = 1'b0; data_in = '0; up_down = 1'b1;
    mode = 2'b00; step = '0; min_val = '0; max_val = '0; clr_flags = 1'b0;
    #1;
    check("rst_count", count, 0);
    check("rst_dir",   dir,   1);
    check("rst_tc",    tc,    0);
    check("rst_done",  done,  0);
    check("rst_ovf",   ovf,   0);
    check("rst_udf",   udf,   0);
    #11;
    rst = 1'b0;

    // Wrap mode counting up from below min
    wrap_exp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd2};
    mode = 2'b00; min_val = 8'd2; max_val = 8'd5; step = 8'd1; up_down = 1'b1; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("wrap_count", count, wrap_exp[i]);
      check("wrap_tc",    tc,    (i == 5));
      check("wrap_ovf",   ovf,   (i == 5));
    end
    en = 1'b0; clr_flags = 1'b1;
    tick();
    check("clr_ovf", ovf, 0);
    check("hold_count", count, 2);
    clr_flags = 1'b0;

    // Saturate down
    mode = 2'b01; min_val = 8'd3; max_val = 8'd200; step = 8'd4; up_down = 1'b0;
    data_in = 8'd10; load = 1'b1;
    tick();
    check("sat_load", count, 10);
    check("sat_load_dir", dir, 0);
    load = 1'b0; en = 1'b1;
    tick();
    check("sat_c1", count, 6);
    check("sat_tc1", tc, 0);
    tick();
    check("sat_c2", count, 3);
    check("sat_tc2", tc, 1);
    check("sat_udf", udf, 1);
    tick();
    check("sat_c3", count, 3);
    check("sat_tc3", tc, 1);
    step = 8'd0;
    tick();
    check("step0_count", count, 3);
    check("step0_tc", tc, 0);

    // Ping-pong ignores up_down once running
    en = 1'b0; mode = 2'b10; min_val = 8'd0; max_val = 8'd3; step = 8'd2;
    up_down = 1'b1; data_in = 8'd0; load = 1'b1;
    tick();
    check("pp_load", count, 0);
    check("pp_load_dir", dir, 1);
    load = 1'b0; en = 1'b1; up_down = 1'b0;
    pp_cnt = '{8'd2, 8'd3, 8'd1, 8'd0, 8'd2};
    pp_dir = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      tick();
      check("pp_count", count, pp_cnt[i]);
      check("pp_dir",   dir,   pp_dir[i]);
      check("pp_tc",    tc,    (i == 1 || i == 3));
    end

    // One-shot, with clr_flags colliding with the overflow event
    en = 1'b0; mode = 2'b11; min_val = 8'd0; max_val = 8'd7; step = 8'd3;
    up_down = 1'b1; data_in = 8'd0; load = 1'b1;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    check("os_c1", count, 3);
    tick();
    check("os_c2", count, 6);
    check("os_done0", done, 0);
    clr_flags = 1'b1;
    tick();
    check("os_c3", count, 7);
    check("os_done", done, 1);
    check("os_tc", tc, 1);
    check("clr_vs_set_ovf", ovf, 1);
    tick();
    check("os_hold", count, 7);
    check("os_hold_tc", tc, 0);
    check("clr_ovf2", ovf, 0);
    check("clr_udf2", udf, 0);
    clr_flags = 1'b0;
    data_in = 8'd4; load = 1'b1;
    tick();
    check("os_reload", count, 4);
    check("os_done_clr", done, 0);
    load = 1'b0;

    // Load clamp and inverted bounds
    en = 1'b0; mode = 2'b00; min_val = 8'd10; max_val = 8'd20; data_in = 8'd50; load = 1'b1;
    tick();
    check("clamp_hi", count, 20);
    data_in = 8'd1;
    tick();
    check("clamp_lo", count, 10);
    data_in = 8'd50;
    tick();
    load = 1'b0;
    check("err_low", err, 0);
    min_val = 8'd30;
    #1;
    check("err_high", err, 1);
    en = 1'b1; step = 8'd1;
    tick();
    check("err_hold", count, 20);
    check("err_tc", tc, 0);
    load = 1'b1;
    tick();
    check("err_load_raw", count, 50);
    load = 1'b0; en = 1'b0;

    // Asynchronous reset between edges
    mode = 2'b00; min_val = 8'd0; max_val = 8'd255; step = 8'd1; up_down = 1'b0;
    data_in = 8'h80; load = 1'b1;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    check("pre_rst_count", count, 8'h7F);
    check("pre_rst_dir", dir, 0);
    #2 rst = 1'b1;
    #1;
    check("async_count", count, 0);
    check("async_dir", dir, 1);
    check("async_tc", tc, 0);
    check("async_ovf", ovf, 0);
    #2 rst = 1'b0;
    up_down = 1'b1;
    tick();
    check("post_rst_count", count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/param_up_down_counter.md
PARAM_UP_DOWN_COUNTER -- requirements
Module: param_up_down_counter

Interface
REQ-001 Parameter WIDTH, default 8, counter/data width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 en  input  1  count enable; low = hold all state except flag clear.
REQ-005 load  input  1  synchronous load of data_in; priority over en.
REQ-006 data_in  input  WIDTH  load value.
REQ-007 up_down  input  1  direction request: 1 = up, 0 = down.
REQ-008 mode  input  2  00 wrap, 01 saturate, 10 ping-pong, 11 one-shot.
REQ-009 step  input  WIDTH  increment/decrement magnitude; 0 = count holds.
REQ-010 min_val, max_val  input  WIDTH each  inclusive count bounds, unsigned.
REQ-011 clr_flags  input  1  synchronous clear of ovf/udf.
REQ-012 count  output  WIDTH  registered counter value.
REQ-013 dir  output  1  registered effective direction (1 = up).
REQ-014 tc  output  1  registered one-cycle terminal-count pulse.
REQ-015 done  output  1  one-shot completion, held until load or rst.
REQ-016 ovf, udf  output  1 each  sticky overflow/underflow flags.
REQ-017 err  output  1  combinational, high while min_val > max_val.

Function
REQ-018 Priority per edge: load > err hold > done hold > en; clr_flags evaluated independently every cycle.
REQ-019 Load: count <= data_in clamped to [min_val, max_val]; dir <= up_down; done, tc <= 0; honoured even when err = 1 (unclamped then).
REQ-020 err = 1 and no load: count, dir, done held; tc = 0.
REQ-021 Effective direction: modes 00/01/11 use up_down each cycle (dir mirrors it when en); mode 10 uses internal dir register.
REQ-022 Arithmetic in WIDTH+1 bits, unsigned; up event when count + step > max_val; down event when count < min_val + step (no wrap of intermediate).
REQ-023 No event: count <= count +/- step; tc <= 0.
REQ-024 Up event: mode 00 count <= min_val; 01 count <= max_val; 10 count <= max_val and dir <= 0; 11 count <= max_val and done <= 1; all modes tc <= 1, ovf <= 1.
REQ-025 Down event: mirror of REQ-024 with min_val/max_val swapped, dir <= 1 in mode 10, udf <= 1.
REQ-026 Saturate mode at a bound re-triggers event each enabled cycle (tc high continuously while pushing into bound).
REQ-027 tc is high only in the cycle following an event edge (latency 1, coincident with new count); otherwise 0.
REQ-028 done = 1: counting frozen regardless of en/mode until load or rst.
REQ-029 step = 0 with en: count unchanged; event still raised if count > max_val (up) or count < min_val (down).
REQ-030 Mode change mid-count takes effect next edge; dir register retains value.
REQ-031 clr_flags and a same-cycle event: set wins (flag = 1).

Reset
REQ-032 rst asserted: immediately count = 0, dir = 1, tc = 0, done = 0, ovf = 0, udf = 0, regardless of clk.
REQ-033 rst mid-count or mid-pulse aborts operation; first edge after release obeys REQ-018 from reset state.

Verification (WIDTH = 8)
REQ-034 Wrap: min 2, max 5, step 1, up, en from count 0 -> 1,2,3,4,5,2; tc and ovf high at second 2.
REQ-035 Saturate down: load 10, min 3, step 4 -> 6, 3, 3; tc high at both 3 cycles, udf = 1.
REQ-036 Ping-pong: min 0, max 3, step 2, load 0 up -> 2, 3 (dir 0), 1, 0 (dir 1), 2.
REQ-037 One-shot: min 0, max 7, step 3, up from 0 -> 3, 6, 7 with done = 1; further en holds 7; load 4 clears done.
REQ-038 Load clamp and err: min 10, max 20, load 50 -> count 20; then min 30 -> err = 1, count holds 20 with en.
REQ-039 Async reset: assert rst between edges mid-count at 0x7F -> count 0, flags 0 before next edge.
